// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the iterative shift unit
//
// Purpose: mode and direction encodings plus the FSM state type used by
// iter_shift_unit and shift_step.
// Ports: none (package).
package shift_pkg;

    localparam logic [1:0] MODE_FILL  = 2'b00;
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-position shift/rotate step
//
// Purpose: advance {data, ovf} by exactly one bit position.
// Ports:
//   data_i   operand before the step
//   ovf_i    shifted-off bits collected so far
//   dir_i    0 = left, 1 = right
//   rot_i    1 = rotate (ovf untouched), 0 = shift with fill
//   fill_i   bit entering the vacated end when not rotating
//   data_o   operand after the step
//   ovf_o    shifted-off bits after the step
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] ovf_i,
    input  logic             dir_i,
    input  logic             rot_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] ovf_o
);

    always_comb begin
        data_o = data_i;
        ovf_o  = ovf_i;
        if (rot_i) begin
            if (dir_i == DIR_LEFT) begin
                data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
            end else begin
                data_o = {data_i[0], data_i[WIDTH-1:1]};
            end
        end else if (dir_i == DIR_LEFT) begin
            // {ovf,data,fill} as one 2*WIDTH+1 vector shifted left by one
            data_o = {data_i[WIDTH-2:0], fill_i};
            ovf_o  = {ovf_i[WIDTH-2:0], data_i[WIDTH-1]};
        end else begin
            // {fill,data,ovf} shifted right by one
            data_o = {fill_i, data_i[WIDTH-1:1]};
            ovf_o  = {data_i[0], ovf_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_shift_unit.sv
// rtl/iter_shift_unit.sv - multi-cycle shift/rotate execution unit
//
// Purpose: shifts one position per cycle under an IDLE/SHIFT/DONE FSM,
// with valid/ready handshakes on request and result.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    request handshake
//   in_data, in_amt      operand and shift amount
//   in_dir, in_mode      direction (0 left) and mode (fill/arith/rotate)
//   in_fill              fill bit for fill mode
//   out_valid/out_ready  result handshake
//   out_data, out_ovf    result and shifted-off bits (zero-padded)
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    input  logic             in_fill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_ovf
);

    localparam int LOG_W = $clog2(WIDTH);
    localparam int CNT_W = LOG_W + 1;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             rot_q;
    logic             fill_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_ovf_q;

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] ovf_d;
    logic [CNT_W-1:0] n_eff;
    logic             fill_sel;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    // Effective count: rotate wraps modulo WIDTH, shifts saturate at WIDTH.
    always_comb begin
        n_eff = '0;
        if (in_mode == MODE_ROT) begin
            n_eff = {1'b0, in_amt[LOG_W-1:0]};
        end else if (in_amt >= AMT_W'(WIDTH)) begin
            n_eff = CNT_W'(WIDTH);
        end else begin
            n_eff = in_amt[CNT_W-1:0];
        end
    end

    always_comb begin
        fill_sel = in_fill;
        case (in_mode)
            MODE_FILL, MODE_RSVD: fill_sel = in_fill;
            MODE_ARITH:           fill_sel = (in_dir == DIR_RIGHT) ? in_data[WIDTH-1] : 1'b0;
            MODE_ROT:             fill_sel = 1'b0;
            default:              fill_sel = in_fill;
        endcase
    end

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .data_i (data_q),
        .ovf_i  (ovf_q),
        .dir_i  (dir_q),
        .rot_i  (rot_q),
        .fill_i (fill_q),
        .data_o (data_d),
        .ovf_o  (ovf_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            ovf_q       <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            rot_q       <= 1'b0;
            fill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        ovf_q  <= '0;
                        dir_q  <= in_dir;
                        rot_q  <= (in_mode == MODE_ROT);
                        fill_q <= fill_sel;
                        cnt_q  <= n_eff;
                        if (n_eff == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= in_data;
                            out_ovf_q   <= '0;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q <= data_d;
                    ovf_q  <= ovf_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    // Result registers load on the final step so they only
                    // ever show a complete result.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= data_d;
                        out_ovf_q   <= ovf_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
Parametrised, multi-cycle shifter with a valid/ready handshake.
- Generalises the 4-bit single-position shift with fill and overflow to WIDTH bits and a variable amount.
- Supports fill, arithmetic and rotate modes.
- Shifts one position per cycle under a small FSM.
- Sits in the integer ALU datapath as the shift/rotate execution unit, between the operand issue stage and the result writeback.

Parameters:
- WIDTH, 8, data width; must be a power of two and at least 2.
- AMT_W, 4, width of the shift-amount port; must be at least clog2(WIDTH)+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept an operation
- in_data  in  WIDTH  operand
- in_amt  in  AMT_W  shift amount
- in_dir  in  1  direction: 0 = left, 1 = right
- in_mode  in  2  mode: 00 = fill, 01 = arithmetic, 10 = rotate, 11 = reserved (behaves as 00)
- in_fill  in  1  fill bit used in fill mode
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  shifted result
- out_ovf  out  WIDTH  bits shifted off, zero-padded

Behaviour:
- Reset:
  - Reset is synchronous, active-high, on clk. While rst=1: state=IDLE, out_valid=0, out_data=0, out_ovf=0, in_ready=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - rst during SHIFT or DONE aborts the operation; no partial result is ever presented.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE) && !rst. No new request is accepted while busy.
- IDLE, accept on in_valid && in_ready at cycle T:
  - Latch data, direction, mode and fill bit; clear the ovf register to 0.
  - The fill bit is:
    - in_fill in fill mode;
    - in_data[WIDTH-1] for arithmetic right;
    - 0 for arithmetic left.
  - Effective count N:
    - rotate: N = in_amt mod WIDTH;
    - otherwise: N = min(in_amt, WIDTH).
  - N=0 -> DONE; otherwise -> SHIFT.
- SHIFT, one position per cycle, count decrements:
  - Left, non-rotate: {ovf,data} <= {ovf,data,fill} shifted left by 1 (a 2*WIDTH register). The shifted-off bit enters ovf[0].
  - Right, non-rotate: {data,ovf} shifted right by 1 with fill entering data[WIDTH-1]. The shifted-off bit enters ovf[WIDTH-1].
  - Rotate: data rotates by 1 in the selected direction; ovf stays 0.
  - When count reaches 0 -> DONE.
- Latency: out_valid rises at T+N+1 (exactly N SHIFT cycles).
- DONE:
  - out_valid=1; out_data/out_ovf equal the data/ovf registers.
  - Both outputs are held stable while out_ready=0.
  - On out_valid && out_ready -> IDLE; out_valid=0 the next cycle. out_data/out_ovf retain their last values.
- Throughput: at best one operation per N+2 cycles.
- Equivalence: N=1 with WIDTH=4 gives results bit-identical to the existing 4-bit shift block, e.g. left on 4'h9 with fill 0 gives out=2, ovf=1.
- in_data, in_amt and the other request inputs are don't-care unless in_valid && in_ready.

Decomposition:
- Package shift_pkg:
  - mode encoding constants: MODE_FILL, MODE_ARITH, MODE_ROT, MODE_RSVD;
  - direction constants: DIR_LEFT, DIR_RIGHT;
  - FSM state typedef: IDLE/SHIFT/DONE.
- Sub-module shift_step:
  - Combinational single-position step.
  - Inputs: data, ovf, dir, rotate flag, fill bit.
  - Outputs: next data, next ovf.
  - Instantiated once in iter_shift_unit. The FSM, counter and handshake stay in the top level.

Test Plan:
- WIDTH=8, fill mode, left, data B4, amt 3, fill 1 -> out_data A7, out_ovf 05; out_valid rises at T+4.
- Arithmetic, right, data 96, amt 2 -> out_data E5, out_ovf 80; out_valid at T+3.
- Rotate, right, data 81, amt 9 (N=1) -> out_data C0, out_ovf 00; out_valid at T+2.
- Boundaries:
  - amt 0, data 5A, any mode -> out_data 5A, out_ovf 00; out_valid at T+1.
  - Fill mode, left, fill 0, data 3C, amt 12 (saturates to 8) -> out_data 00, out_ovf 3C; out_valid at T+9.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_data/out_ovf unchanged, in_ready=0.
  - A concurrent in_valid pulse is ignored.
  - After out_ready=1, in_ready=1 the next cycle.
- Reset:
  - Assert rst mid-SHIFT -> next cycle out_valid=0, outputs 0.
  - After rst deasserts, in_ready=1 and a fresh operation completes correctly.
